simon_key_unroller: RTL

- Inverse (reverse-direction) key schedule for SIMON64/128 decryption.
- Loaded once with the final four round keys k40..k43; streams all 44 round keys in descending order, k43 first, k0 last, over a valid/ready interface.
- Feeds the decryption datapath, which consumes round keys in reverse.
- Reconstructs each earlier key by inverting the forward key-expansion step, one key per accepted beat.

---
 rtl/simon_pkg.sv | 29 ++
 rtl/simon_key_step_inv.sv | 27 ++
 rtl/simon_key_unroller.sv | 114 +++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// simon_pkg
// Shared constants and helpers for the SIMON64/128 inverse key schedule.
//   WORD     : round-key word width (32 only)
//   ROUNDS   : number of round keys (44 only)
//   C_CONST  : ~3, the constant folded into every key-expansion step
//   Z3       : z3 sequence, index 0 is the leftmost character
//   ror()    : rotate right
//   z3_bit() : z3 bit at position (j mod 62)
package simon_pkg;

    localparam int WORD   = 32;
    localparam int ROUNDS = 44;

    localparam logic [0:WORD-1] C_CONST = 32'hFFFF_FFFC;

    localparam logic [0:61] Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;

    function automatic logic [0:WORD-1] ror(input logic [0:WORD-1] x, input int unsigned r);
        return (x >> r) | (x << (WORD - r));
    endfunction

    function automatic logic z3_bit(input logic [5:0] j);
        logic [5:0] m;
        m = (j >= 6'd62) ? j - 6'd62 : j;
        return Z3[m];
    endfunction

endpackage

// File: rtl/simon_key_step_inv.sv
// simon_key_step_inv
// One inverted SIMON64/128 key-expansion step (purely combinational).
// With a3=k[j+4], a2=k[j+3], a0=k[j+1] and z=z3[j mod 62] it recovers k[j].
//   a3, a2, a0 : window words (bit 0 = MSB)
//   z          : z3 sequence bit for index j
//   kj         : reconstructed round key k[j]
module simon_key_step_inv
    import simon_pkg::*;
(
    input  logic [0:WORD-1] a3,
    input  logic [0:WORD-1] a2,
    input  logic [0:WORD-1] a0,
    input  logic            z,
    output logic [0:WORD-1] kj
);

    logic [0:WORD-1] t;
    logic [0:WORD-1] y;

    always_comb begin
        t  = ror(a2, 3) ^ a0;
        y  = t ^ ror(t, 1);
        // z only touches the LSB, which is bit WORD-1 in this big-endian numbering
        kj = a3 ^ C_CONST ^ y ^ {{(WORD-1){1'b0}}, z};
    end

endmodule

// File: rtl/simon_key_unroller.sv
// simon_key_unroller
// Streams the 44 SIMON64/128 round keys in descending order (k43 .. k0),
// starting from the last four keys and undoing the key expansion one step
// per accepted beat.
//   clk, rst_n             : clock, synchronous active-low reset
//   load_valid/load_ready  : load handshake, key_in = {k43,k42,k41,k40}
//   rk_valid/rk_ready      : round-key stream handshake
//   rk, rk_idx, rk_last    : round key (bit 0 = MSB), its index, last flag
//   busy                   : stream in progress
//
// state     | meaning
// ST_IDLE   | waiting for a load, load_ready=1, rk_valid=0
// ST_STREAM | presenting rk, one key per accepted beat, busy=1
module simon_key_unroller
    import simon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [0:4*WORD-1] key_in,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [0:WORD-1]   rk,
    output logic [5:0]        rk_idx,
    output logic              rk_last,
    output logic              busy
);

    typedef enum logic {ST_IDLE, ST_STREAM} state_t;

    state_t          state;
    state_t          state_next;
    logic [0:WORD-1] a0, a1, a2, a3;
    logic [5:0]      idx;
    logic            fire_load;
    logic            fire_beat;
    logic            z_bit;
    logic [0:WORD-1] k_prev;

    assign fire_load = load_valid && (state == ST_IDLE);
    assign fire_beat = rk_ready && (state == ST_STREAM);
    assign z_bit     = z3_bit(idx - 6'd1);

    simon_key_step_inv u_step (
        .a3 (a3),
        .a2 (a2),
        .a0 (a0),
        .z  (z_bit),
        .kj (k_prev)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        rk_valid   = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                rk_valid = 1'b1;
                busy     = 1'b1;
                if (rk_ready && idx == 6'd0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // idx doubles as the down-counter sequencing the stream; the first three
    // beats only replay loaded words, after that the window slides back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a0  <= '0;
            a1  <= '0;
            a2  <= '0;
            a3  <= '0;
            rk  <= '0;
            idx <= '0;
        end else if (fire_load) begin
            a3  <= key_in[0:WORD-1];
            a2  <= key_in[WORD:2*WORD-1];
            a1  <= key_in[2*WORD:3*WORD-1];
            a0  <= key_in[3*WORD:4*WORD-1];
            rk  <= key_in[0:WORD-1];
            idx <= 6'(ROUNDS - 1);
        end else if (fire_beat && idx != 6'd0) begin
            idx <= idx - 6'd1;
            case (idx)
                6'd43:   rk <= a2;
                6'd42:   rk <= a1;
                6'd41:   rk <= a0;
                default: begin
                    rk <= k_prev;
                    a3 <= a2;
                    a2 <= a1;
                    a1 <= a0;
                    a0 <= k_prev;
                end
            endcase
        end
    end

    assign rk_idx  = idx;
    assign rk_last = rk_valid && (idx == 6'd0);

endmodule
